// File: rtl/comp_8bits_arb_if.sv
// Request/result bundle for comp_8bits_arb: two valid/ready producers and one
// valid/ready result channel. The arbiter connects through the slave modport.
interface comp_8bits_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/comp_8bits_arb.sv
// Round-robin arbiter sharing one comp_8bits complement unit between two
// requesters. Optional per-requester grant counters: define COMP_ARB_STATS_EN.
module comp_8bits (
  input  logic [7:0] x_i,
  output logic [7:0] y_o
);
  logic [6:0] neg_low;

  // 7-bit add wraps on purpose, so 8'h80 maps to itself
  assign neg_low = ~x_i[6:0] + 7'd1;
  assign y_o     = x_i[7] ? {1'b1, neg_low} : x_i;
endmodule

module comp_8bits_arb #(
  parameter bit          START_PRI = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  comp_8bits_arb_if.slave   bus
`ifdef COMP_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic       ptr_q, ptr_d;

  logic       can_accept;
  logic       gnt0, gnt1;
  logic       rdy0, rdy1;
  logic [7:0] comp_in;
  logic [7:0] comp_out;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  comp_8bits u_comp (
    .x_i (comp_in),
    .y_o (comp_out)
  );

  always_comb begin
    can_accept = (state_q == EMPTY) | bus.res_ready;
    // Contention resolved by the pointer; a lone requester always wins.
    gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
    rdy0 = can_accept & gnt0;
    rdy1 = can_accept & gnt1;
    comp_in = rdy1 ? bus.req1_data : bus.req0_data;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: begin
        if (rdy0 | rdy1) state_d = FULL;
      end
      FULL: begin
        if (!(rdy0 | rdy1) && bus.res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (rdy0 | rdy1) begin
      data_d = comp_out;
      id_d   = rdy1;
      ptr_d  = ~rdy1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      ptr_q   <= START_PRI;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = (state_q == FULL);
  assign bus.res_data   = data_q;
  assign bus.res_id     = id_q;

`ifdef COMP_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rdy0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (rdy1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_comp_8bits_arb.sv
// Directed-vector bench for comp_8bits_arb; expected values hand-computed
// from the complement rule. Covers the stats counters when COMP_ARB_STATS_EN is set.
module tb_comp_8bits_arb;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_err;

  comp_8bits_arb_if bus ();

`ifdef COMP_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;
`endif

  comp_8bits_arb #(
    .START_PRI (1'b0),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COMP_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_dat;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.res_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_valid", 16'(bus.res_valid), 16'h0);
    check("rst_data",  16'(bus.res_data),  16'h00);
    check("rst_id",    16'(bus.res_id),    16'h0);
    check("rst_rdy0",  16'(bus.req0_ready), 16'h0);
    check("rst_rdy1",  16'(bus.req1_ready), 16'h0);
`ifdef COMP_ARB_STATS_EN
    check("rst_cnt0",  16'(gnt_cnt0), 16'h0);
    check("rst_cnt1",  16'(gnt_cnt1), 16'h0);
`endif
    rst_n = 1'b1;

    // Single requester
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h1B;
    #1;
    check("single_rdy0", 16'(bus.req0_ready), 16'h1);
    check("single_rdy1", 16'(bus.req1_ready), 16'h0);
    tick();
    check("single_v1",  16'(bus.res_valid), 16'h1);
    check("single_d1B", 16'(bus.res_data),  16'h1B);
    check("single_id",  16'(bus.res_id),    16'h0);
    bus.req0_data = 8'h49;
    tick();
    check("single_d49", 16'(bus.res_data), 16'h49);
    bus.req0_data = 8'hC9;
    tick();
    check("single_dC9", 16'(bus.res_data), 16'hB7);
    bus.req0_data = 8'h80;
    tick();
    check("single_d80", 16'(bus.res_data), 16'h80);
    check("single_id2", 16'(bus.res_id),   16'h0);
    bus.req0_valid = 1'b0;
    tick();
    check("drain_valid", 16'(bus.res_valid), 16'h0);
    check("drain_hold",  16'(bus.res_data),  16'h80);
    tick();
    check("idle_valid",  16'(bus.res_valid), 16'h0);

    // Pointer back to START_PRI before contention
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // Contention: 0,1,0,1
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hD6;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hAA;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_rdy0", 16'(bus.req0_ready), 16'((i % 2) == 0));
      check("cont_rdy1", 16'(bus.req1_ready), 16'((i % 2) == 1));
      tick();
      exp_dat = ((i % 2) == 0) ? 8'hAA : 8'hD6;
      check("cont_id",   16'(bus.res_id),   16'(i % 2));
      check("cont_data", 16'(bus.res_data), 16'(exp_dat));
    end

    // Backpressure with FULL buffer holding D6 from requester 1
    bus.req0_valid = 1'b0;
    bus.req1_data  = 8'hFF;
    bus.res_ready  = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rdy0",  16'(bus.req0_ready), 16'h0);
      check("bp_rdy1",  16'(bus.req1_ready), 16'h0);
      tick();
      check("bp_valid", 16'(bus.res_valid),  16'h1);
      check("bp_data",  16'(bus.res_data),   16'hD6);
      check("bp_id",    16'(bus.res_id),     16'h1);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_rel_rdy1", 16'(bus.req1_ready), 16'h1);
    check("bp_rel_rdy0", 16'(bus.req0_ready), 16'h0);
    tick();
    check("bp_rel_data", 16'(bus.res_data), 16'h81);
    check("bp_rel_id",   16'(bus.res_id),   16'h1);

    // Move pointer to 1, then leave buffer FULL
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h02;
    tick();
    check("pre_rst_data", 16'(bus.res_data), 16'h02);
    bus.req0_valid = 1'b0;
    bus.res_ready  = 1'b0;
    #2;

    // Mid-stream reset, checked between clock edges
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(bus.res_valid), 16'h0);
    check("mid_rst_data",  16'(bus.res_data),  16'h00);
    check("mid_rst_id",    16'(bus.res_id),    16'h0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("mid_rst_ptr0", 16'(bus.req0_ready), 16'h1);
    check("mid_rst_ptr1", 16'(bus.req1_ready), 16'h0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;

`ifdef COMP_ARB_STATS_EN
    // Counter saturation at CNT_W=2
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h11;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("cnt0_sat", 16'(gnt_cnt0), 16'((i > 3) ? 3 : i));
      check("cnt1_idle", 16'(gnt_cnt1), 16'h0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    tick();
    check("cnt1_one", 16'(gnt_cnt1), 16'h1);
    check("cnt0_hold", 16'(gnt_cnt0), 16'h3);
    bus.req1_valid = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
